// File: rtl/i2c_pkg.sv
// Shared constants for the write-only I2C target: FSM state encodings and bus levels.
package i2c_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE     = 3'd0;
  localparam state_t ADDR     = 3'd1;
  localparam state_t ADDR_ACK = 3'd2;
  localparam state_t DATA     = 3'd3;
  localparam state_t DATA_ACK = 3'd4;
  localparam state_t IGNORE   = 3'd5;

  localparam logic ACK_LEVEL = 1'b0;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for one I2C pin plus a history flop for rise/fall detection.
module i2c_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  // Idle bus is pulled high, so reset to 1 to avoid a phantom edge after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      hist <= 1'b1;
    end else begin
      meta <= pin;
      sync <= meta;
      hist <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~hist;
  assign fall  = ~sync & hist;

endmodule

// File: rtl/i2c.sv
// Write-only 7-bit-address I2C target: ACKs its address and each data byte, strobes out received bytes.
module i2c
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS = 7'h4A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  output logic       scl_o,
  input  logic       sda_i,
  output logic       sda_o,
  output logic [7:0] data,
  output logic       data_valid_o,
  output logic       start,
  output logic       stop
);

  logic       scl_level, scl_rise, scl_fall;
  logic       sda_level, sda_rise, sda_fall;
  logic       start_cond, stop_cond;
  state_t     state;
  logic [7:0] shift;
  logic [3:0] bit_cnt;

  i2c_sync_edge u_scl (
    .clk  (clk),
    .reset(reset),
    .pin  (scl_i),
    .level(scl_level),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_sync_edge u_sda (
    .clk  (clk),
    .reset(reset),
    .pin  (sda_i),
    .level(sda_level),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  assign scl_o      = 1'b1;
  assign start_cond = sda_fall & scl_level;
  assign stop_cond  = sda_rise & scl_level;

  // START/STOP override whatever the FSM was doing, including an SCL edge in the same clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      shift        <= 8'h00;
      bit_cnt      <= 4'd0;
      sda_o        <= 1'b1;
      data         <= 8'h00;
      data_valid_o <= 1'b0;
      start        <= 1'b0;
      stop         <= 1'b0;
    end else begin
      start        <= 1'b0;
      stop         <= 1'b0;
      data_valid_o <= 1'b0;
      if (start_cond) begin
        start   <= 1'b1;
        sda_o   <= 1'b1;
        bit_cnt <= 4'd0;
        state   <= ADDR;
      end else if (stop_cond) begin
        stop    <= 1'b1;
        sda_o   <= 1'b1;
        bit_cnt <= 4'd0;
        state   <= IDLE;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shift   <= {shift[6:0], sda_level};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              // Only a write to our own address is acknowledged; reads are never ACKed.
              if (shift == {ADDRESS, 1'b0}) begin
                sda_o <= ACK_LEVEL;
                state <= ADDR_ACK;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              sda_o <= 1'b1;
              state <= DATA;
            end
          end
          DATA: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shift   <= {shift[6:0], sda_level};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                data         <= {shift[6:0], sda_level};
                data_valid_o <= 1'b1;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_o <= ACK_LEVEL;
              state <= DATA_ACK;
            end
          end
          DATA_ACK: begin
            if (scl_fall) begin
              sda_o   <= 1'b1;
              bit_cnt <= 4'd0;
              state   <= DATA;
            end
          end
          IDLE, IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c.sv
// Directed bench for the I2C target: a table of write transactions plus hand-written corner sequences.
module tb_i2c;

  typedef struct {
    logic [7:0] addr_byte;
    int         nbytes;
    logic [7:0] bytes [2];
    bit         end_stop;
    bit         exp_ack;
    int         exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_i;
  logic       m_sda;
  logic       sda_i;
  logic       scl_o;
  logic       sda_o;
  logic [7:0] data;
  logic       data_valid_o;
  logic       start;
  logic       stop;

  int         tests = 0;
  int         failures = 0;
  int         start_cnt = 0;
  int         stop_cnt = 0;
  int         valid_cnt = 0;
  logic [7:0] last_valid_data = 8'h00;
  bit         in_data_bit = 1'b0;
  bit         sda_low_seen = 1'b0;
  vec_t       vecs [5];

  always #5 clk = ~clk;

  // Open-drain bus: the line is low if either the master or the target pulls it.
  assign sda_i = m_sda & sda_o;

  i2c #(.ADDRESS(7'h4A)) dut (
    .clk         (clk),
    .reset       (reset),
    .scl_i       (scl_i),
    .scl_o       (scl_o),
    .sda_i       (sda_i),
    .sda_o       (sda_o),
    .data        (data),
    .data_valid_o(data_valid_o),
    .start       (start),
    .stop        (stop)
  );

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (start === 1'b1) start_cnt++;
      if (stop === 1'b1) stop_cnt++;
      if (data_valid_o === 1'b1) begin
        valid_cnt++;
        last_valid_data = data;
      end
      if (in_data_bit && sda_o !== 1'b1) sda_low_seen = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered and left with SCL low; SDA only changes during the low phase.
  task automatic send_bit(input logic b, input bit is_data, output logic sampled);
    m_sda = b;
    wait_clks(4);
    scl_i = 1'b1;
    in_data_bit = is_data;
    wait_clks(4);
    sampled = sda_o;
    wait_clks(4);
    in_data_bit = 1'b0;
    scl_i = 1'b0;
    wait_clks(4);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack_level);
    logic dummy;
    for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b1, dummy);
    send_bit(1'b1, 1'b0, ack_level);
  endtask

  task automatic bus_start();
    m_sda = 1'b1;
    wait_clks(4);
    scl_i = 1'b1;
    wait_clks(4);
    m_sda = 1'b0;
    wait_clks(4);
    scl_i = 1'b0;
    wait_clks(4);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0;
    wait_clks(4);
    scl_i = 1'b1;
    wait_clks(4);
    m_sda = 1'b1;
    wait_clks(8);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int   s0, p0, d0;
    logic ack;
    s0 = start_cnt;
    p0 = stop_cnt;
    d0 = valid_cnt;
    sda_low_seen = 1'b0;
    bus_start();
    send_byte(v.addr_byte, ack);
    checkOutput($sformatf("v%0d addr_ack", idx), ack, v.exp_ack ? 0 : 1);
    for (int j = 0; j < v.nbytes; j++) begin
      send_byte(v.bytes[j], ack);
      checkOutput($sformatf("v%0d data_ack%0d", idx, j), ack, v.exp_ack ? 0 : 1);
      if (v.exp_ack) checkOutput($sformatf("v%0d byte%0d", idx, j), last_valid_data, v.bytes[j]);
    end
    if (v.end_stop) bus_stop();
    checkOutput($sformatf("v%0d start_pulses", idx), start_cnt - s0, 1);
    checkOutput($sformatf("v%0d stop_pulses", idx), stop_cnt - p0, v.end_stop ? 1 : 0);
    checkOutput($sformatf("v%0d valid_pulses", idx), valid_cnt - d0, v.exp_valid);
    checkOutput($sformatf("v%0d data", idx), data, v.exp_data);
    checkOutput($sformatf("v%0d sda_released_in_bits", idx), sda_low_seen, 0);
  endtask

  initial begin
    int   s0, p0, d0;
    logic ack;
    logic dummy;

    vecs[0] = '{8'h94, 2, '{8'h71, 8'hA8}, 1'b0, 1'b1, 2, 8'hA8};
    vecs[1] = '{8'h94, 1, '{8'hA8, 8'h00}, 1'b1, 1'b1, 1, 8'hA8};
    vecs[2] = '{8'h96, 1, '{8'h55, 8'h00}, 1'b1, 1'b0, 0, 8'hA8};
    vecs[3] = '{8'h95, 1, '{8'h33, 8'h00}, 1'b1, 1'b0, 0, 8'hA8};
    vecs[4] = '{8'h94, 2, '{8'hC3, 8'h0F}, 1'b1, 1'b1, 2, 8'h0F};

    scl_i = 1'b1;
    m_sda = 1'b1;
    reset = 1'b1;
    wait_clks(4);
    checkOutput("reset sda_o", sda_o, 1);
    checkOutput("reset scl_o", scl_o, 1);
    checkOutput("reset data", data, 8'h00);
    checkOutput("reset valid", data_valid_o, 0);
    checkOutput("reset start", start, 0);
    checkOutput("reset stop", stop, 0);
    reset = 1'b0;
    wait_clks(4);

    // Idle bus: SCL toggling with SDA static high must produce nothing.
    for (int i = 0; i < 10; i++) begin
      scl_i = 1'b0;
      wait_clks(4);
      scl_i = 1'b1;
      wait_clks(4);
    end
    checkOutput("idle start_pulses", start_cnt, 0);
    checkOutput("idle stop_pulses", stop_cnt, 0);
    checkOutput("idle valid_pulses", valid_cnt, 0);
    checkOutput("idle sda_o", sda_o, 1);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

    // STOP in the middle of a data byte: partial byte dropped, target idle afterwards.
    p0 = stop_cnt;
    d0 = valid_cnt;
    bus_start();
    send_byte(8'h94, ack);
    checkOutput("midstop addr_ack", ack, 0);
    send_bit(1'b1, 1'b1, dummy);
    send_bit(1'b0, 1'b1, dummy);
    send_bit(1'b1, 1'b1, dummy);
    send_bit(1'b1, 1'b1, dummy);
    bus_stop();
    checkOutput("midstop stop_pulses", stop_cnt - p0, 1);
    checkOutput("midstop valid_pulses", valid_cnt - d0, 0);
    checkOutput("midstop data", data, 8'h0F);
    s0 = start_cnt;
    sda_low_seen = 1'b0;
    scl_i = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 8; i++) send_bit(i[0], 1'b1, dummy);
    send_bit(1'b1, 1'b0, ack);
    checkOutput("after_stop no_ack", ack, 1);
    checkOutput("after_stop sda_released", sda_low_seen, 0);
    checkOutput("after_stop start_pulses", start_cnt - s0, 0);

    // Repeated START mid-byte aborts the partial byte without a valid strobe.
    s0 = start_cnt;
    d0 = valid_cnt;
    bus_start();
    send_byte(8'h94, ack);
    send_bit(1'b0, 1'b1, dummy);
    send_bit(1'b1, 1'b1, dummy);
    send_bit(1'b1, 1'b1, dummy);
    bus_start();
    send_byte(8'h94, ack);
    checkOutput("abort addr_ack", ack, 0);
    send_byte(8'h5A, ack);
    checkOutput("abort data_ack", ack, 0);
    bus_stop();
    checkOutput("abort start_pulses", start_cnt - s0, 2);
    checkOutput("abort valid_pulses", valid_cnt - d0, 1);
    checkOutput("abort data", data, 8'h5A);

    // Reset in the middle of a data byte returns everything to reset values.
    d0 = valid_cnt;
    bus_start();
    send_byte(8'h94, ack);
    send_bit(1'b1, 1'b1, dummy);
    send_bit(1'b1, 1'b1, dummy);
    reset = 1'b1;
    wait_clks(2);
    checkOutput("midreset sda_o", sda_o, 1);
    checkOutput("midreset data", data, 8'h00);
    checkOutput("midreset valid", data_valid_o, 0);
    checkOutput("midreset start", start, 0);
    checkOutput("midreset stop", stop, 0);
    reset = 1'b0;
    wait_clks(2);
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1, dummy);
    send_bit(1'b1, 1'b0, ack);
    checkOutput("midreset no_ack", ack, 1);
    checkOutput("midreset valid_pulses", valid_cnt - d0, 0);
    checkOutput("midreset data_kept", data, 8'h00);
    bus_stop();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/i2c.md
Name: i2c

Overview:
- Write-only I2C target (slave) with a 7-bit address; samples the external SCL/SDA pins in the system clock domain.
- Acknowledges its own address and each received data byte, and presents every received byte on a parallel output with a one-cycle valid strobe.
- Flags START/repeated-START and STOP conditions.
- Sits between the chip's bidirectional I2C pads (external tristate/open-drain logic) and internal register logic.

Parameters:
- ADDRESS, 7'h4A, 7-bit target address matched against the first byte after START.

Ports:
- clk  input  1  system clock; must be at least 8x faster than SCL.
- reset  input  1  synchronous, active-high reset.
- scl_i  input  1  SCL pin level.
- scl_o  output  1  SCL drive value; 1 = released. Tied to 1 (no clock stretching).
- sda_i  input  1  SDA pin level.
- sda_o  output  1  SDA drive value; 1 = released, 0 = pull low (ACK).
- data  output  8  last received data byte, MSB first on the wire.
- data_valid_o  output  1  one-clk pulse when `data` is updated.
- start  output  1  one-clk pulse on START or repeated START.
- stop  output  1  one-clk pulse on STOP.

Behaviour:
- Reset values: sda_o=1, scl_o=1, data=8'h00, data_valid_o=0, start=0, stop=0; state IDLE; shift register and bit counter cleared.
- Input conditioning:
  - scl_i and sda_i each pass through a 2-flop synchronizer, then one history flop for edge detection.
  - All bus events are detected 3 clk after the pin change.
- Bus events:
  - START: SDA falling while SCL high.
  - STOP: SDA rising while SCL high.
  - Data bits are sampled on the SCL rising edge.
  - sda_o changes only on SCL falling edges.
- START (any state) pulses `start`, clears the bit counter and goes to ADDR. This aborts any byte in progress; a partial byte is discarded with no data_valid_o.
- STOP (any state) pulses `stop`, releases SDA and goes to IDLE.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits (7 address bits + R/W). On the SCL falling edge after the 8th bit:
    - address == ADDRESS and R/W==0: sda_o=0, go to ADDR_ACK.
    - otherwise: keep sda_o=1 and go to IGNORE.
    - Reads (R/W==1) are never acknowledged.
  - ADDR_ACK: hold sda_o=0 through the 9th SCL pulse; on its falling edge set sda_o=1 and go to DATA.
  - DATA: shift in 8 bits MSB first.
    - On the 8th SCL rising edge, load `data` with the full byte and pulse data_valid_o for exactly one clk.
    - On the following SCL falling edge, set sda_o=0 and go to DATA_ACK.
  - DATA_ACK: hold ACK through the 9th pulse; on its falling edge release SDA, clear the counter, return to DATA. Unlimited bytes per transfer.
  - IGNORE: SDA released; leave only on START or STOP.
- `data` holds its value until the next complete byte or reset.
- START and STOP are mutually exclusive per clk. A START detected in the same clk as an SCL edge takes priority over that edge.
- Reset asserted mid-transfer returns to IDLE immediately, with outputs at reset values.

Decomposition:
- Package i2c_pkg: state enumeration (IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE) and constant ACK_LEVEL=1'b0.
- Sub-module i2c_sync_edge: 2-flop synchronizer plus rise/fall detect, instantiated once for SCL and once for SDA.
- FSM and shift register stay in the top.

Test Plan:
- Reset pulse, then idle bus with SCL toggling and SDA static: all outputs at reset values, no start/stop pulses.
- SDA falls while SCL high, then address bits 1001010 with W=0: exactly one start pulse; sda_o=0 during the 9th SCL high phase; sda_o=1 before and after.
- After the address, send bytes 0x71 then 0xA8: data_valid_o pulses twice; data=8'h71 then 8'hA8; ACK (sda_o=0) on each 9th clock.
- Repeated START without STOP, address 0x4A write, byte 0xA8: second start pulse, no stop; address ACKed; data=8'hA8 with one valid pulse.
- Address 0x4B write, or 0x4A with R/W=1: sda_o stays 1 for the entire transfer; no data_valid_o until the next START.
- SDA rises while SCL high mid-byte: one stop pulse; partial byte dropped; FSM in IDLE (following SCL clocks cause no ACK).
